irq_encoder16: RTL

- Registered 16-to-4 priority encoder with a valid/ack handshake; the inverse of the 4-to-16 decoders used for register and device select.
- Captures rising edges on 16 request lines into a pending register and applies a mask.
- Presents the highest-priority pending index to the MIPS core as a stable 4-bit code until the core acknowledges it.
- Sits between peripheral interrupt lines and the CPU exception/control logic.

---
 rtl/irq_encoder16.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/irq_encoder16.sv
// ----------------------------------------------------------------------------
// irq_encoder16
//
// Registered 16-to-4 interrupt priority encoder with a valid/ack handshake.
// Rising edges on the request lines are latched into a pending register.
// The highest-priority pending and enabled request is presented to the CPU
// as a 4-bit code. The code is held stable until the CPU acknowledges it.
//
// Parameters
//   PRIO_HIGH_FIRST : 1 = bit 15 has the highest priority, 0 = bit 0 does
//   MASK_RESET      : reset value of the mask register (1 = enabled)
//
// Ports
//   clk      in   1   clock, all state changes on the rising edge
//   rst      in   1   synchronous active-high reset
//   req      in  16   request lines, rising-edge detected
//   mask_we  in   1   mask write strobe
//   mask_in  in  16   new mask value, written when mask_we = 1
//   ack      in   1   CPU acknowledge of the presented code
//   code     out  4   index of the presented request
//   valid    out  1   code is valid and held stable
//   pending  out 16   raw pending register (unmasked)
//   mask     out 16   current mask register
// ----------------------------------------------------------------------------
module irq_encoder16 #(
    parameter bit          PRIO_HIGH_FIRST = 1'b1,
    parameter logic [15:0] MASK_RESET      = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        mask_we,
    input  logic [15:0] mask_in,
    input  logic        ack,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pending,
    output logic [15:0] mask
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [15:0] req_q_reg;
    logic [15:0] pending_reg;
    logic [15:0] pending_next;
    logic [15:0] mask_reg;
    logic [15:0] mask_next;
    logic [3:0]  code_reg;
    logic [3:0]  code_next;

    logic [15:0] req_edge;
    logic [15:0] clr;
    logic [15:0] eligible;
    logic [3:0]  sel_index;
    logic        ack_taken;

    // ------------------------------------------------------------------
    // Per-bit edge detection and pending update. The clear is only ever
    // one-hot (the presented code), and a new edge on the same bit wins
    // over the clear so a re-raised request is never lost.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign req_edge[gi]     = req[gi] & ~req_q_reg[gi];
            assign clr[gi]          = ack_taken && (code_reg == 4'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | req_edge[gi];
        end
    endgenerate

    // Selection uses the mask as registered this cycle; a mask write in the
    // same cycle only affects selection from the next cycle on.
    assign eligible  = pending_reg & mask_reg;
    assign mask_next = mask_we ? mask_in : mask_reg;

    // ------------------------------------------------------------------
    // Priority encoder. The scan runs from lowest to highest priority so
    // that the last set bit seen is the winner.
    // ------------------------------------------------------------------
    always_comb begin
        sel_index = 4'd0;
        if (PRIO_HIGH_FIRST) begin
            for (int i = 0; i < 16; i++) begin
                if (eligible[i]) begin
                    sel_index = 4'(i);
                end
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (eligible[i]) begin
                    sel_index = 4'(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM, next-state logic. In PRESENT the code is frozen even
    // if a higher-priority request arrives or the presented bit is masked.
    // ack has no effect in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        ack_taken  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (eligible != 16'h0000) begin
                    code_next  = sel_index;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    ack_taken  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. req_q resets to zero so a request held high across
    // reset release registers as one fresh edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            req_q_reg   <= 16'h0000;
            pending_reg <= 16'h0000;
            mask_reg    <= MASK_RESET;
            code_reg    <= 4'd0;
        end else begin
            state_reg   <= state_next;
            req_q_reg   <= req;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            code_reg    <= code_next;
        end
    end

    assign code    = code_reg;
    assign valid   = (state_reg == PRESENT);
    assign pending = pending_reg;
    assign mask    = mask_reg;

endmodule
